vga_text_pixel: RTL and testbench



---
 rtl/vga_text_pixel.sv | 111 +++++++++++
 tb/tb_vga_text_pixel.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vga_text_pixel.sv
// vga_text_pixel: text-mode pixel generator for an 80x30 grid of 8x16 cells
// on a 640x480 raster. It sits behind the VGA timing controller.
//
// Optional feature: define VGA_TEXT_BLINK_EN to build a per-frame blink
// counter. With it, attr bit 7 selects blink and the background is limited
// to 8 colours.
//
// Ports:
//   clk      pixel clock; hx advances on the same edge
//   rst      asynchronous, active-high reset
//   hx, vy   column (0..799) and line (0..524) counters
//   text_a   text/colour RAM address {vy[8:4], hx[9:3]} (combinational)
//   text_d   character code from the text RAM
//   color_d  attribute from the colour RAM: [3:0] fg, [7:4] bg
//   font_a   font ROM address {char, vy[3:0]} (combinational from register)
//   font_d   font row, bit 7 = leftmost pixel
//   rgbi     registered pixel colour {i, r, g, b}
module vga_text_pixel #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned BLINK_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hx,
  input  logic [9:0]  vy,
  output logic [11:0] text_a,
  input  logic [7:0]  text_d,
  input  logic [7:0]  color_d,
  output logic [11:0] font_a,
  input  logic [7:0]  font_d,
  output logic [3:0]  rgbi
);

  localparam logic [9:0] L_HVIS = 10'(H_VISIBLE);
  localparam logic [9:0] L_VVIS = 10'(V_VISIBLE);

  logic [7:0] r_char;
  logic [7:0] r_attr;
  logic       r_vis;
  logic [7:0] r_shift;
  logic [7:0] r_attr_s;
  logic       r_vis_s;
  logic [3:0] r_rgbi;

  logic       w_fetch;
  logic       w_load;
  logic [3:0] w_fg;
  logic [3:0] w_bg;

  // Cell phase 3 latches RAM data; phase 7 loads the font row into the shifter.
  assign w_fetch = (hx[2:0] == 3'd3);
  assign w_load  = (hx[2:0] == 3'd7);

  assign text_a = {vy[8:4], hx[9:3]};
  assign font_a = {r_char, vy[3:0]};
  assign rgbi   = r_rgbi;

`ifdef VGA_TEXT_BLINK_EN
  logic [BLINK_BITS-1:0] r_frame;
  logic                  w_hide;

  // Frame counter ticks once per frame at the start of vertical blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame <= '0;
    end else if ((hx == 10'd0) && (vy == L_VVIS)) begin
      r_frame <= r_frame + BLINK_BITS'(1);
    end
  end

  // Blinking cells hide the glyph by drawing it in the background colour.
  assign w_bg   = {1'b0, r_attr_s[6:4]};
  assign w_hide = r_attr_s[7] & r_frame[BLINK_BITS-1];
  assign w_fg   = w_hide ? w_bg : r_attr_s[3:0];
`else
  logic [BLINK_BITS-1:0] w_unused_blink;

  assign w_unused_blink = '0;
  assign w_bg           = r_attr_s[7:4];
  assign w_fg           = r_attr_s[3:0];
`endif

  // Fetch and shift pipeline. Pixels leave 8 clocks after their column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_char   <= 8'h00;
      r_attr   <= 8'h00;
      r_vis    <= 1'b0;
      r_shift  <= 8'h00;
      r_attr_s <= 8'h00;
      r_vis_s  <= 1'b0;
      r_rgbi   <= 4'h0;
    end else begin
      if (w_fetch) begin
        r_char <= text_d;
        r_attr <= color_d;
        r_vis  <= (hx < L_HVIS) && (vy < L_VVIS);
      end
      if (w_load) begin
        r_shift  <= r_vis ? font_d : 8'h00;
        r_attr_s <= r_attr;
        r_vis_s  <= r_vis;
      end else begin
        r_shift <= {r_shift[6:0], 1'b0};
      end
      r_rgbi <= r_vis_s ? (r_shift[7] ? w_fg : w_bg) : 4'h0;
    end
  end

endmodule

// File: tb/tb_vga_text_pixel.sv
// Scoreboard bench for vga_text_pixel. The driver presents hx/vy at each
// falling edge and queues the response it expects after the next rising
// edge. The monitor pops one entry per rising edge and compares.
module tb_vga_text_pixel;

  logic        clk;
  logic        rst;
  logic [9:0]  hx;
  logic [9:0]  vy;
  logic [11:0] text_a;
  logic [7:0]  text_d;
  logic [7:0]  color_d;
  logic [11:0] font_a;
  logic [7:0]  font_d;
  logic [3:0]  rgbi;

  vga_text_pixel dut (
    .clk     (clk),
    .rst     (rst),
    .hx      (hx),
    .vy      (vy),
    .text_a  (text_a),
    .text_d  (text_d),
    .color_d (color_d),
    .font_a  (font_a),
    .font_d  (font_d),
    .rgbi    (rgbi)
  );

  typedef struct {
    logic        chk_rgb;
    logic [3:0]  rgb;
    logic        chk_ta;
    logic [11:0] ta;
    logic        chk_fa;
    logic [11:0] fa;
    logic [11:0] fa_mask;
    int          h;
    int          v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per rising edge, sampled just after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk_rgb) begin
        n_checks++;
        if (rgbi !== e.rgb) begin
          n_errors++;
          $display("FAIL rgbi hx=%0d vy=%0d got %h want %h", e.h, e.v, rgbi, e.rgb);
        end
      end
      if (e.chk_ta) begin
        n_checks++;
        if (text_a !== e.ta) begin
          n_errors++;
          $display("FAIL text_a hx=%0d vy=%0d got %h want %h", e.h, e.v, text_a, e.ta);
        end
      end
      if (e.chk_fa) begin
        n_checks++;
        if ((font_a & e.fa_mask) !== e.fa) begin
          n_errors++;
          $display("FAIL font_a hx=%0d vy=%0d got %h want %h (mask %h)",
                   e.h, e.v, font_a, e.fa, e.fa_mask);
        end
      end
    end
  end

  task automatic step(input int h, input int v, input logic r,
                      input logic cr, input logic [3:0] er,
                      input logic ct, input logic [11:0] et,
                      input logic cf, input logic [11:0] ef, input logic [11:0] mf);
    exp_t e;
    @(negedge clk);
    hx  = 10'(h);
    vy  = 10'(v);
    rst = r;
    e.chk_rgb = cr;  e.rgb = er;
    e.chk_ta  = ct;  e.ta  = et;
    e.chk_fa  = cf;  e.fa  = ef;  e.fa_mask = mf;
    e.h = h;  e.v = v;
    q.push_back(e);
  endtask

  // Expected pixel on a visible line with every cell holding the same data.
  function automatic logic [3:0] line_pix(input int h, input logic [7:0] f,
                                          input logic [7:0] a);
    logic [3:0] fg;
    logic [3:0] bg;
    fg = a[3:0];
`ifdef VGA_TEXT_BLINK_EN
    bg = {1'b0, a[6:4]};
`else
    bg = a[7:4];
`endif
    if (h >= 8 && h < 648) return f[3'(7 - ((h - 8) % 8))] ? fg : bg;
    return 4'h0;
  endfunction

  // Full 800-column line; reset is held on column rst_h, and columns
  // zlo..zhi are forced to black. Addresses are checked on columns alo..ahi.
  task automatic run_line(input int v, input int rst_h, input int zlo, input int zhi,
                          input int alo, input int ahi, input logic [11:0] ta_e,
                          input logic [11:0] fa_e, input logic [11:0] fa_m);
    logic [3:0] er;
    logic       ca;
    for (int h = 0; h < 800; h++) begin
      if (v >= 480 || (h >= zlo && h <= zhi)) er = 4'h0;
      else er = line_pix(h, font_d, color_d);
      ca = (h >= alo && h <= ahi);
      step(h, v, (h == rst_h), 1'b1, er, ca, ta_e, ca, fa_e, fa_m);
    end
  endtask

  initial begin
    logic [3:0] exp_on;
    logic [3:0] exp_bg90;
    rst = 1'b1; hx = '0; vy = '0;
    text_d = 8'h00; color_d = 8'h00; font_d = 8'h00;

    // Reset state.
    for (int i = 0; i < 3; i++) step(0, 0, 1'b1, 1'b1, 4'h0, 1'b0, 0, 1'b0, 0, 0);

    // Line 0, char 0x41, attr 0x1E, font row 0x81.
    text_d = 8'h41; color_d = 8'h1E; font_d = 8'h81;
    run_line(0, -1, -1, -2, 4, 7, 12'h000, 12'h410, 12'hFFF);

    // Line 37: row 2 addressing, right-edge blanking.
    text_d = 8'h20; color_d = 8'h5A; font_d = 8'hA5;
    run_line(37, -1, -1, -2, 635, 635, 12'h14F, 12'h005, 12'h00F);

    // Vertical blanking lines with busy data buses.
    text_d = 8'hFF; color_d = 8'hFF; font_d = 8'hFF;
    for (int v = 480; v < 525; v++) run_line(v, -1, -1, -2, -1, -2, 0, 0, 0);

    // Frame restart at line 0.
    text_d = 8'h41; color_d = 8'h1E; font_d = 8'h81;
    run_line(0, -1, -1, -2, -1, -2, 0, 0, 0);

    // Mid-line reset at hx=100 on line 50: black until cell 13 at hx=112.
    text_d = 8'h33; color_d = 8'h2C; font_d = 8'hF0;
    run_line(50, 100, 100, 111, -1, -2, 0, 0, 0);

    // Blink test from a clean reset: attr 0x9F, solid glyph.
    for (int i = 0; i < 2; i++) step(0, 0, 1'b1, 1'b1, 4'h0, 1'b0, 0, 1'b0, 0, 0);
    text_d = 8'h42; color_d = 8'h9F; font_d = 8'hFF;
    for (int k = 0; k <= 32; k++) begin
`ifdef VGA_TEXT_BLINK_EN
      exp_on = ((k % 32) >= 16) ? 4'h1 : 4'hF;
`else
      exp_on = 4'hF;
`endif
      for (int h = 0; h < 16; h++)
        step(h, 0, 1'b0, 1'b1, (h < 8) ? 4'h0 : exp_on, 1'b0, 0, 1'b0, 0, 0);
      for (int h = 0; h < 8; h++) step(h, 480, 1'b0, 1'b0, 4'h0, 1'b0, 0, 1'b0, 0, 0);
    end

    // Attr 0x90 with an empty glyph shows only the background.
`ifdef VGA_TEXT_BLINK_EN
    exp_bg90 = 4'h1;
`else
    exp_bg90 = 4'h9;
`endif
    color_d = 8'h90; font_d = 8'h00;
    for (int h = 0; h < 16; h++)
      step(h, 0, 1'b0, 1'b1, (h < 8) ? 4'h0 : exp_bg90, 1'b0, 0, 1'b0, 0, 0);

    // Drain the scoreboard.
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
